// File: rtl/decoder_pkg.sv
// Shared widths and arbiter state type for the request encoder and the
// downstream 3-to-8 decoder.
package decoder_pkg;
  localparam int IDX_W   = 3;
  localparam int N_LINES = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority finder: first set bit of req scanning
// start, start+1, ... wrapping modulo N_LINES.
module rr_pick
  import decoder_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   sel
);
  logic [2*N_LINES-1:0] dbl;
  logic [N_LINES-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotating the request vector right by start turns the search into a
  // plain lowest-set-bit priority encode.
  assign dbl = {req, req} >> start;
  assign rot = dbl[N_LINES-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N_LINES-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k[IDX_W-1:0];
      end
    end
  end

  assign sel = start + off;
endmodule

// File: rtl/rr_req_encoder.sv
// Round-robin request encoder with bounded bursts; drives the registered
// valid/idx pair consumed by the 3-to-8 decoder.
module rr_req_encoder
  import decoder_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_LINES-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [3:0]         burst
);
  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [3:0]       burst_q, burst_d;

  logic             found;
  logic [IDX_W-1:0] sel;

  rr_pick u_pick (
    .req   (req),
    .start (ptr_q),
    .found (found),
    .sel   (sel)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        burst_d = '0;
        if (en && found) begin
          state_d = GRANT;
          valid_d = 1'b1;
          idx_d   = sel;
          burst_d = 4'd1;
          ptr_d   = sel + 1'b1;
        end
      end
      GRANT: begin
        if (!en) begin
          state_d = IDLE;
          valid_d = 1'b0;
          burst_d = '0;
        end else if (req[idx_q] && burst_q < MAXB) begin
          burst_d = burst_q + 4'd1;
        end else if (found) begin
          // ptr sits at idx+1, so the current holder is considered last.
          valid_d = 1'b1;
          idx_d   = sel;
          burst_d = 4'd1;
          ptr_d   = sel + 1'b1;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      burst_q <= burst_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;
  assign burst = burst_q;
endmodule

// File: tb/tb_rr_req_encoder.sv
// Bench for rr_req_encoder: MAX_BURST=4 and MAX_BURST=1 instances against a
// behavioural arbitration model, plus a behavioural decoder on the second.
module tb_rr_req_encoder;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] req;
  logic       v4, v1;
  logic [2:0] i4, i1;
  logic [3:0] b4, b1;
  logic [7:0] dec_out;

  int errs = 0, checks = 0;

  typedef struct {bit v; int idx; int burst; int ptr;} mdl_t;
  mdl_t m4, m1, m1_prev;

  rr_req_encoder #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .valid(v4), .idx(i4), .burst(b4)
  );
  rr_req_encoder #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .valid(v1), .idx(i1), .burst(b1)
  );

  always #5 clk = ~clk;

  // Downstream 3-to-8 decoder stage fed by the MAX_BURST=1 instance.
  always @(posedge clk) dec_out <= v1 ? (8'd1 << i1) : 8'd0;

  function automatic mdl_t step(mdl_t m, bit rs, bit e, logic [7:0] r, int maxb);
    mdl_t n = m;
    int w = -1;
    if (!rs) begin
      n.v = 0; n.idx = 0; n.burst = 0; n.ptr = 0;
      return n;
    end
    if (!e) begin
      n.v = 0; n.burst = 0;
      return n;
    end
    if (m.v && r[m.idx] && m.burst < maxb) begin
      n.burst = m.burst + 1;
      return n;
    end
    for (int k = 0; k < 8; k++)
      if (w < 0 && r[(m.ptr + k) % 8]) w = (m.ptr + k) % 8;
    if (w < 0) begin
      n.v = 0; n.burst = 0;
    end else begin
      n.v = 1; n.idx = w; n.burst = 1; n.ptr = (w + 1) % 8;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rs, bit e, logic [7:0] r, bit chk_dec = 0);
    rst = rs; en = e; req = r;
    @(posedge clk);
    m1_prev = m1;
    m4 = step(m4, rs, e, r, 4);
    m1 = step(m1, rs, e, r, 1);
    #1;
    chk("valid4", 32'(v4), 32'(m4.v));
    chk("idx4",   32'(i4), 32'(m4.idx));
    chk("burst4", 32'(b4), 32'(m4.burst));
    chk("valid1", 32'(v1), 32'(m1.v));
    chk("idx1",   32'(i1), 32'(m1.idx));
    chk("burst1", 32'(b1), 32'(m1.burst));
    if (chk_dec)
      chk("dec_out", 32'(dec_out), m1_prev.v ? 32'(8'd1 << m1_prev.idx) : 32'd0);
  endtask

  initial begin
    int exp_idx[9]   = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
    int exp_burst[9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
    m4 = '{0, 0, 0, 0};
    m1 = '{0, 0, 0, 0};
    rst = 1'b0; en = 1'b1; req = 8'hFF;

    // Reset held with all requesting, then first grant on release
    cyc(0, 1, 8'hFF);
    cyc(0, 1, 8'hFF);
    chk("rst_valid", 32'(v4), 32'd0);
    chk("rst_idx",   32'(i4), 32'd0);
    chk("rst_burst", 32'(b4), 32'd0);
    cyc(1, 1, 8'hFF);
    chk("rel_valid", 32'(v4), 32'd1);
    chk("rel_idx",   32'(i4), 32'd0);

    // Burst limit with two requesters
    cyc(0, 1, 8'h00);
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 8'h05);
      chk("bl_idx",   32'(i4), 32'(exp_idx[k]));
      chk("bl_burst", 32'(b4), 32'(exp_burst[k]));
    end

    // Lone requester at index 7, then wrap to 0
    cyc(0, 1, 8'h00);
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 8'h80);
      chk("lone_idx",   32'(i4), 32'd7);
      chk("lone_burst", 32'(b4), 32'((k % 4) + 1));
      chk("lone_valid", 32'(v4), 32'd1);
    end
    for (int k = 0; k < 4; k++) cyc(1, 1, 8'h81);
    chk("wrap_idx", 32'(i4), 32'd0);

    // Early drop then no requests
    cyc(0, 1, 8'h00);
    cyc(1, 1, 8'h03);
    chk("drop_idx0", 32'(i4), 32'd0);
    cyc(1, 1, 8'h02);
    chk("drop_idx1", 32'(i4), 32'd1);
    chk("drop_b1",   32'(b4), 32'd1);
    cyc(1, 1, 8'h00);
    chk("drop_idle", 32'(v4), 32'd0);

    // Enable gating mid-burst on index 3
    cyc(1, 1, 8'h08);
    cyc(1, 1, 8'h08);
    cyc(1, 0, 8'h08);
    chk("en_off", 32'(v4), 32'd0);
    cyc(1, 0, 8'h08);
    cyc(1, 1, 8'h08);
    chk("en_idx",   32'(i4), 32'd3);
    chk("en_burst", 32'(b4), 32'd1);

    // End-to-end through the decoder, pure round-robin
    cyc(0, 1, 8'hFF);
    for (int k = 0; k < 18; k++) cyc(1, 1, 8'hFF, k > 0);
    chk("dec_last", 32'(dec_out), 32'(8'd1 << 0));

    // Fairness with all requesting: each index MAX_BURST cycles, in order
    cyc(0, 1, 8'h00);
    for (int k = 0; k < 40; k++) begin
      cyc(1, 1, 8'hFF);
      chk("fair_idx", 32'(i4), 32'((k / 4) % 8));
    end

    // Randomized traffic with occasional disable and reset
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
